// File: rtl/mult15127_rr_sequencer.sv
// mult15127_rr_sequencer: two-requester round-robin, four-step shared add/sub multiplier computing x*15127 mod 2^WIDTH
// Ports: i_clk/i_rst (async active-high); i_valid0/i_data0/o_ready0 and i_valid1/i_data1/o_ready1 requester handshakes;
// o_valid/o_data0/o_id/i_ready result handshake; o_busy (not IDLE); o_done_cnt (wrapping handoff count).
module mult15127_rr_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid0,
  input  logic [WIDTH-1:0] i_data0,
  output logic             o_ready0,
  input  logic             i_valid1,
  input  logic [WIDTH-1:0] i_data1,
  output logic             o_ready1,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data0,
  output logic             o_id,
  input  logic             i_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_done_cnt
);
  typedef enum logic [2:0] {IDLE, OP1, OP2, OP3, OP4, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] rx_q, rx_d, ra_q, ra_d;
  logic prio_q, prio_d, id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    o_ready0 = (state_q == IDLE) & i_valid0 & (~i_valid1 | ~prio_q);
    o_ready1 = (state_q == IDLE) & i_valid1 & (~i_valid0 | prio_q);
    state_d = state_q;
    rx_d = rx_q;
    ra_d = ra_q;
    prio_d = prio_q;
    id_d = id_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (o_ready0 | o_ready1) begin
        rx_d = o_ready1 ? i_data1 : i_data0;
        id_d = o_ready1;
        prio_d = ~o_ready1;
        state_d = OP1;
      end
      OP1: begin
        ra_d = (rx_q << 7) - rx_q;
        state_d = OP2;
      end
      OP2: begin
        ra_d = ra_q + (ra_q << 4);
        state_d = OP3;
      end
      OP3: begin
        ra_d = ra_q + (rx_q << 1);
        state_d = OP4;
      end
      OP4: begin
        ra_d = (ra_q << 3) - ra_q;
        state_d = DONE;
      end
      DONE: if (i_ready) begin
        state_d = IDLE;
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      rx_q <= '0;
      ra_q <= '0;
      prio_q <= 1'b0;
      id_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rx_q <= rx_d;
      ra_q <= ra_d;
      prio_q <= prio_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_valid = (state_q == DONE);
  assign o_busy = (state_q != IDLE);
  assign o_data0 = ra_q;
  assign o_id = id_q;
  assign o_done_cnt = cnt_q;
endmodule
